// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: BIST controller for the c17 benchmark netlist.
// It drives 5-bit patterns into a c17 instance and compacts the 2-bit
// responses into an 8-bit MISR (x^8+x^6+x^5+x^4+1). It flags pass or fail
// against a golden signature.
// Optional feature macro: C17_BIST_LFSR_EN. When it is defined, the pattern
// source is a 5-bit LFSR (x^5+x^3+1) instead of a binary counter.
module c17_bist_ctrl #(
  parameter int         NUM_PAT    = 32,
  parameter logic [7:0] SIG_GOLDEN = 8'h00,
  parameter logic [7:0] SIG_SEED   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] resp_i,
  output logic [4:0] pat_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

`ifdef C17_BIST_LFSR_EN
  // The LFSR never produces zero, so at most 31 distinct patterns exist.
  localparam int         EFF_PAT   = (NUM_PAT > 31) ? 31 : NUM_PAT;
  localparam logic [4:0] PAT_FIRST = 5'b00001;
`else
  localparam int         EFF_PAT   = NUM_PAT;
  localparam logic [4:0] PAT_FIRST = 5'b00000;
`endif

  localparam logic [4:0] LAST_IDX = 5'(EFF_PAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state;
  logic [4:0] idx;
  logic [7:0] misr_next;
  logic [4:0] pat_next;
  logic       fb;

  // Next MISR value: shift in the polynomial feedback, then fold in the response.
  always_comb begin
    fb        = signature[7] ^ signature[5] ^ signature[4] ^ signature[3];
    misr_next = {signature[6:0], fb} ^ {6'b0, resp_i};
  end

  // Next pattern from the selected pattern source.
  always_comb begin
`ifdef C17_BIST_LFSR_EN
    pat_next = {pat_o[3:0], pat_o[4] ^ pat_o[2]};
`else
    pat_next = pat_o + 5'd1;
`endif
  end

  // Control FSM. All outputs are registered here.
  // A reset during a run drops every partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 5'd0;
      pat_o     <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= SIG_SEED;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            idx       <= 5'd0;
            pat_o     <= PAT_FIRST;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SIG_SEED;
          end
        end
        RUN: begin
          signature <= misr_next;
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_next == SIG_GOLDEN);
          end else begin
            idx   <= idx + 5'd1;
            pat_o <= pat_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb_c17_bist_ctrl: self-checking bench for c17_bist_ctrl.
// It runs a full-length instance against a behavioural run model, plus two
// short instances (one pattern, and two forced responses) that are checked
// against hand-computed values.
module tb_c17_bist_ctrl;

`ifdef C17_BIST_LFSR_EN
  localparam int         TB_N        = 31;
  localparam logic [4:0] PAT0        = 5'h01;
  localparam logic [1:0] SINGLE_RESP = 2'b01;
  localparam logic [7:0] SINGLE_SIG  = 8'h01;
  localparam logic       SINGLE_PASS = 1'b0;
  localparam logic [4:0] PAT4        = 5'h12;
  localparam logic [31:0] SEEN_ALL   = 32'hFFFF_FFFE;
`else
  localparam int         TB_N        = 32;
  localparam logic [4:0] PAT0        = 5'h00;
  localparam logic [1:0] SINGLE_RESP = 2'b00;
  localparam logic [7:0] SINGLE_SIG  = 8'h00;
  localparam logic       SINGLE_PASS = 1'b1;
  localparam logic [4:0] PAT4        = 5'h04;
  localparam logic [31:0] SEEN_ALL   = 32'hFFFF_FFFF;
`endif

  localparam logic [7:0] SEED = 8'h00;

  // Reference behaviour written directly from the rules for the c17 circuit,
  // the MISR polynomial and the pattern sequence.
  function automatic logic [1:0] c17_resp(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
    logic f;
    f = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], f} ^ {6'b0, r};
  endfunction

  function automatic logic [4:0] pat_at(input int k);
`ifdef C17_BIST_LFSR_EN
    logic [4:0] p;
    p = 5'b00001;
    for (int i = 0; i < k; i++) p = {p[3:0], p[4] ^ p[2]};
    return p;
`else
    return 5'(k);
`endif
  endfunction

  function automatic logic [7:0] calc_gold();
    logic [7:0] s;
    s = SEED;
    for (int k = 0; k < TB_N; k++) s = misr_step(s, c17_resp(pat_at(k)));
    return s;
  endfunction

  localparam logic [7:0] C17_GOLD = calc_gold();

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;
  logic cmp_en = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Full-length instance, response is the c17 model or bench random data.
  logic       start_main = 1'b0;
  logic       use_c17 = 1'b1;
  logic [1:0] rnd_resp = 2'b00;
  logic [1:0] resp_main;
  logic [4:0] pat_main;
  logic       busy_main, done_main, pass_main;
  logic [7:0] sig_main;
  assign resp_main = use_c17 ? c17_resp(pat_main) : rnd_resp;

  c17_bist_ctrl #(.NUM_PAT(TB_N), .SIG_GOLDEN(C17_GOLD), .SIG_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_main), .resp_i(resp_main),
    .pat_o(pat_main), .busy(busy_main), .done(done_main), .pass(pass_main),
    .signature(sig_main)
  );

  // Single-pattern instance with c17 attached.
  logic       start1 = 1'b0;
  logic [1:0] resp1;
  logic [4:0] pat1;
  logic       busy1, done1, pass1;
  logic [7:0] sig1;
  assign resp1 = c17_resp(pat1);

  c17_bist_ctrl #(.NUM_PAT(1), .SIG_GOLDEN(8'h00), .SIG_SEED(SEED)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .resp_i(resp1),
    .pat_o(pat1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  // Two-pattern instance with forced responses.
  logic       start2 = 1'b0;
  logic [1:0] resp2 = 2'b00;
  logic [4:0] pat2;
  logic       busy2, done2, pass2;
  logic [7:0] sig2;

  c17_bist_ctrl #(.NUM_PAT(2), .SIG_GOLDEN(8'h00), .SIG_SEED(SEED)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .resp_i(resp2),
    .pat_o(pat2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] r, input logic c);
    start_main = s;
    rnd_resp   = r;
    use_c17    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDoneMain(input int max_cycles, output int cycles);
    cycles = 0;
    while (!done_main && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("done_timeout", done_main, 1);
  endtask

  // Run model: a run is "how many responses have been absorbed so far". It
  // is busy below TB_N absorbed responses and done once TB_N are absorbed.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_sig = SEED;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_sig    = SEED;
    end else if (m_active && m_k < TB_N) begin
      m_sig = misr_step(m_sig, resp_main);
      m_k   = m_k + 1;
    end else if (start_main) begin
      m_active = 1'b1;
      m_k      = 0;
      m_sig    = SEED;
    end
  end

  // Per-cycle comparison of the full-length instance against the run model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic       e_busy, e_done;
      logic [4:0] e_pat;
      e_busy = m_active && (m_k < TB_N);
      e_done = m_active && (m_k == TB_N);
      e_pat  = m_active ? pat_at((m_k < TB_N) ? m_k : TB_N - 1) : 5'd0;
      checkOutput("cyc_busy", busy_main, e_busy);
      checkOutput("cyc_done", done_main, e_done);
      checkOutput("cyc_pat", pat_main, e_pat);
      checkOutput("cyc_sig", sig_main, m_sig);
      checkOutput("cyc_pass", pass_main, e_done && (m_sig == C17_GOLD));
    end
  end

  // Pattern recorder for sequence and coverage checks of a run.
  bit          rec_en = 1'b0;
  int          rec_cnt = 0;
  logic [31:0] seen = 32'd0;
  logic [4:0]  first_pats [5];

  always @(negedge clk) begin
    if (rec_en && busy_main) begin
      if (rec_cnt < 5) first_pats[rec_cnt] = pat_main;
      seen[pat_main] = 1'b1;
      rec_cnt++;
    end
  end

  task automatic sweepRun(input string tag);
    int lat;
    rec_cnt = 0;
    seen    = 32'd0;
    rec_en  = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b1);
    start_main = 1'b0;
    waitDoneMain(TB_N + 8, lat);
    rec_en = 1'b0;
    checkOutput({tag, "_latency"}, lat, TB_N);
    checkOutput({tag, "_busy_cycles"}, rec_cnt, TB_N);
    checkOutput({tag, "_pat_cover"}, seen, SEEN_ALL);
    checkOutput({tag, "_first_pat"}, first_pats[0], PAT0);
    checkOutput({tag, "_fifth_pat"}, first_pats[4], PAT4);
    checkOutput({tag, "_sig"}, sig_main, C17_GOLD);
    checkOutput({tag, "_pass"}, pass_main, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;

    // Model pins against hand-computed values.
    checkOutput("model_misr_a", misr_step(8'h00, 2'b11), 8'h03);
    checkOutput("model_misr_b", misr_step(8'h03, 2'b00), 8'h06);
    checkOutput("model_c17_0", c17_resp(5'h00), 2'b00);
    checkOutput("model_c17_1", c17_resp(5'h01), 2'b01);
    checkOutput("model_pat4", pat_at(4), PAT4);

    // Reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_pat", pat_main, 0);
    checkOutput("rst_busy", busy_main, 0);
    checkOutput("rst_done", done_main, 0);
    checkOutput("rst_pass", pass_main, 0);
    checkOutput("rst_sig", sig_main, 8'h00);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_sig2", sig2, 8'h00);
    cmp_en = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pattern with real c17.
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checkOutput("single_busy", busy1, 1);
    checkOutput("single_pat", pat1, PAT0);
    checkOutput("single_resp", resp1, SINGLE_RESP);
    @(posedge clk);
    #1;
    checkOutput("single_busy_fall", busy1, 0);
    checkOutput("single_done", done1, 1);
    checkOutput("single_sig", sig1, SINGLE_SIG);
    checkOutput("single_pass", pass1, SINGLE_PASS);

    // MISR arithmetic with forced responses.
    start2 = 1'b1;
    resp2  = 2'b11;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    checkOutput("misr_busy", busy2, 1);
    @(posedge clk);
    #1;
    checkOutput("misr_sig1", sig2, 8'h03);
    checkOutput("misr_busy1", busy2, 1);
    resp2 = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("misr_sig2", sig2, 8'h06);
    checkOutput("misr_done", done2, 1);
    checkOutput("misr_busy2", busy2, 0);
    checkOutput("misr_pass", pass2, 0);

    // Full sweep with real c17.
    sweepRun("sweep");

    // Abort at pattern 10, then restart.
    applyStimulus(1'b1, 2'b00, 1'b1);
    start_main = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_at10", pat_main, pat_at(10));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_pat", pat_main, 0);
    checkOutput("abort_busy", busy_main, 0);
    checkOutput("abort_sig", sig_main, SEED);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweepRun("restart");

    // Randomized traffic: random responses, start pulses (also during RUN)
    // and occasional asynchronous resets; checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) pulseReset();
      else applyStimulus($urandom_range(0, 5) == 0, 2'($urandom), 1'($urandom));
    end

    // Start held high: back-to-back runs with a one-cycle DONE.
    for (int i = 0; i < 3 * (TB_N + 1); i++) applyStimulus(1'b1, 2'($urandom), 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1);
    waitDoneMain(TB_N + 8, lat);
    checkOutput("hold_sig", sig_main, C17_GOLD);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Built-in self-test controller for the c17 benchmark netlist. Applies a deterministic sequence of 5-bit input patterns to a c17 instance and compacts its 2-bit responses into an 8-bit multiple-input signature register (MISR). At the end of the run it compares the signature against a golden value and reports pass or fail. Sits beside the c17 instance and replaces the open-loop stimulus bench with a self-checking closed loop.

## Interface
Parameters:
- `NUM_PAT`, default 32: number of patterns applied per run. Legal range 1..32.
- `SIG_GOLDEN`, default 8'h00: expected final signature.
- `SIG_SEED`, default 8'h00: MISR value at the start of each run.

Ports:
- Reset is asynchronous, active-low, on `rst_n`; `clk` is the single clock.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begins a run when sampled high in IDLE or DONE.
- `pat_o` output 5: registered pattern to the CUT. `[4]`=N1, `[3]`=N2, `[2]`=N3, `[1]`=N6, `[0]`=N7.
- `resp_i` input 2: CUT response. `[1]`=N22, `[0]`=N23. The CUT path is combinational from `pat_o`.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE; held until the next start or reset.
- `pass` output 1: valid when `done`=1. Equals `signature==SIG_GOLDEN`; 0 otherwise.
- `signature` output 8: current MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → RUN.
  - On that edge: MISR is loaded with `SIG_SEED`, the pattern index is cleared, and `pat_o` is loaded with the first pattern.
- RUN:
  - Each clock edge, the MISR absorbs `resp_i`, the index increments, and `pat_o` advances.
  - On the edge that absorbs the `NUM_PAT`-th response → DONE. `pat_o` holds its last value.
  - `start` is ignored in RUN.
- DONE:
  - `done`=1. `pass` is registered on entry.
  - `start`=1 → restart, identical to the IDLE→RUN transition.
- MISR update (primitive polynomial x^8+x^6+x^5+x^4+1):
  - fb = s[7]^s[5]^s[4]^s[3]
  - s_next = {s[6:0],fb} ^ {6'b0,resp_i}
- Pattern source (default): binary counter. Pattern k = k[4:0], starting at 0.
- Reset values: state=IDLE, `pat_o`=0, `busy`=0, `done`=0, `pass`=0, `signature`=`SIG_SEED`.
- Reset asserted mid-run aborts immediately to the reset values. No partial result is reported.

## Timing
- `start` sampled at edge E0 → `busy`=1 and pattern 0 on `pat_o` after E0.
- The response to pattern k is captured at edge E(k+1); one cycle of settle time is available for the CUT.
- `busy` stays high for exactly `NUM_PAT` cycles.
- `done` and `pass` rise after edge E(`NUM_PAT`), in the same cycle `busy` falls.
- Run-to-done latency is `NUM_PAT` cycles after the start edge.
- `start` held high continuously: a new run begins on the first edge in DONE. DONE lasts 1 cycle.

## Configuration
- `C17_BIST_LFSR_EN` defined:
  - Pattern source is a 5-bit Fibonacci LFSR, x^5+x^3+1, seeded 5'b00001 at start.
  - Update: p_next = {p[3:0], p[4]^p[2]}.
  - Pattern 0 is never applied. `NUM_PAT` is clamped to 31.
- Not defined: binary counter as described in Operation.
- The MISR, FSM and timing are identical in both modes.

## Test plan
- Reset:
  - Assert `rst_n`=0 with no clock.
  - Required: `pat_o`=0, `busy`=0, `done`=0, `pass`=0, `signature`=8'h00 immediately.
- Single pattern:
  - `NUM_PAT`=1, real c17 attached, `start` pulse.
  - Required: `pat_o`=5'b00000, `resp_i`=2'b00, `signature`=8'h00, `pass`=1 with `SIG_GOLDEN`=8'h00. `busy` is high for 1 cycle.
- MISR arithmetic:
  - `NUM_PAT`=2, `resp_i` forced to 2'b11 then 2'b00.
  - Required: `signature`=8'h03 after the first capture, 8'h06 after the second. `pass`=0 with golden 8'h00.
- Full sweep, counter mode:
  - `NUM_PAT`=32, real c17.
  - Required: `pat_o` steps 0..31 on consecutive cycles, `busy` high 32 cycles, final `signature` matches the bench reference model, `pass`=1 when `SIG_GOLDEN` is set to that value.
- Abort and restart:
  - Drop `rst_n` at pattern 10, release, then `start` again.
  - Required: `pat_o` restarts at 0, final signature equals the uninterrupted run.
  - `start` pulsed during RUN has no effect.
- LFSR mode, `C17_BIST_LFSR_EN` defined:
  - `NUM_PAT`=31.
  - Required: first patterns are 01, 02, 04, 09, 12 (hex). All 31 nonzero values appear once. `done` rises after 31 cycles.
